// File: rtl/serdes_rx_framer.sv
`default_nettype none
// ============================================================================
// Module   : serdes_rx_framer
// Purpose  : Serial receive framer: start-bit hunt, LSB-first byte capture,
//            parity/stop checks, held valid/read handshake with overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module serdes_rx_framer #(
   parameter int PARITY_EN  = 1,
   parameter int ODD_PARITY = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ser_en,
   input  logic       ser_in,
   input  logic       rd_en,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   localparam logic c_par_en  = (PARITY_EN != 0);
   localparam logic c_par_odd = (ODD_PARITY != 0);

   state_t     r_state;
   logic [2:0] r_bit_cnt;
   logic [7:0] r_shift;
   logic       r_par_bit;
   logic [7:0] r_data_out;
   logic       r_data_valid;
   logic       r_parity_err;
   logic       r_frame_err;
   logic       r_overrun;
   logic       r_busy;
   logic       w_par_err;

   // XOR of data and parity bit is 0 for a good even frame, 1 for a good odd frame
   assign w_par_err = c_par_en & ((^{r_shift, r_par_bit}) ^ c_par_odd);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_bit_cnt    <= 3'd0;
         r_shift      <= 8'h00;
         r_par_bit    <= 1'b0;
         r_data_out   <= 8'h00;
         r_data_valid <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         // A completing byte below overrides this clear when both land on one edge
         if (r_data_valid && rd_en) begin
            r_data_valid <= 1'b0;
         end
         if (ser_en) begin
            case (r_state)
               S_IDLE: begin
                  if (!ser_in) begin
                     r_state   <= S_DATA;
                     r_bit_cnt <= 3'd0;
                     r_busy    <= 1'b1;
                  end
               end
               S_DATA: begin
                  r_shift[r_bit_cnt] <= ser_in;
                  r_bit_cnt          <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= c_par_en ? S_PARITY : S_STOP;
                  end
               end
               S_PARITY: begin
                  r_par_bit <= ser_in;
                  r_state   <= S_STOP;
               end
               S_STOP: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  if (!ser_in) begin
                     r_frame_err <= 1'b1;
                  end else if (!r_data_valid || rd_en) begin
                     r_data_out   <= r_shift;
                     r_data_valid <= 1'b1;
                     r_parity_err <= w_par_err;
                  end else begin
                     r_overrun <= 1'b1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign data_out   = r_data_out;
   assign data_valid = r_data_valid;
   assign parity_err = r_parity_err;
   assign frame_err  = r_frame_err;
   assign overrun    = r_overrun;
   assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_serdes_rx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serdes_rx_framer
// Purpose  : Directed self-checking bench for serdes_rx_framer (even parity).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serdes_rx_framer;

   logic       clk;
   logic       rst;
   logic       ser_en;
   logic       ser_in;
   logic       rd_en;
   logic [7:0] data_out;
   logic       data_valid;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
   } exp_t;

   exp_t q_exp[$];
   int   n_assert;
   int   n_fail;
   logic r_dv_before_stop;

   serdes_rx_framer #(.PARITY_EN(1), .ODD_PARITY(0)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .ser_en     (ser_en),
      .ser_in     (ser_in),
      .rd_en      (rd_en),
      .data_out   (data_out),
      .data_valid (data_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input int gap);
      ser_en = 1'b1;
      ser_in = b;
      tick();
      ser_en = 1'b0;
      ser_in = 1'b1;
      for (int i = 0; i < gap; i++) tick();
   endtask

   // Sends one frame; pushes the expected byte when the bench expects acceptance
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                             input int gap, input logic rd_on_stop, input logic accept);
      send_bit(1'b0, gap);
      chk("busy_after_start", {31'b0, busy}, 32'd1);
      for (int i = 0; i < 8; i++) send_bit(d[i], gap);
      send_bit(par, gap);
      r_dv_before_stop = data_valid;
      rd_en  = rd_on_stop;
      ser_en = 1'b1;
      ser_in = stop;
      if (accept) q_exp.push_back('{d: d, pe: (^d) ^ par});
      tick();
      rd_en  = 1'b0;
      ser_en = 1'b0;
      ser_in = 1'b1;
   endtask

   task automatic check_frame(input string tag);
      exp_t e;
      chk({tag, "_sb_nonempty"}, {31'b0, q_exp.size() != 0}, 32'd1);
      if (q_exp.size() != 0) begin
         e = q_exp.pop_front();
         chk({tag, "_data"}, {24'b0, data_out}, {24'b0, e.d});
         chk({tag, "_perr"}, {31'b0, parity_err}, {31'b0, e.pe});
      end
      chk({tag, "_valid"}, {31'b0, data_valid}, 32'd1);
      chk({tag, "_ferr"}, {31'b0, frame_err}, 32'd0);
      chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
   endtask

   task automatic do_read(input string tag, input logic [7:0] held);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk({tag, "_rd_valid"}, {31'b0, data_valid}, 32'd0);
      chk({tag, "_rd_data"}, {24'b0, data_out}, {24'b0, held});
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_data"}, {24'b0, data_out}, 32'd0);
      chk({tag, "_valid"}, {31'b0, data_valid}, 32'd0);
      chk({tag, "_perr"}, {31'b0, parity_err}, 32'd0);
      chk({tag, "_ferr"}, {31'b0, frame_err}, 32'd0);
      chk({tag, "_ovr"}, {31'b0, overrun}, 32'd0);
      chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst      = 1'b1;
      ser_en   = 1'b0;
      ser_in   = 1'b1;
      rd_en    = 1'b0;
      r_dv_before_stop = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();

      // Basic byte, ser_en tied high
      send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0, 1'b1);
      chk("basic_dv_before_stop", {31'b0, r_dv_before_stop}, 32'd0);
      check_frame("basic");
      do_read("basic", 8'hA5);

      // Wrong parity bit in even mode
      send_frame(8'h3C, 1'b1, 1'b1, 0, 1'b0, 1'b1);
      check_frame("parity");
      chk("parity_perr_set", {31'b0, parity_err}, 32'd1);
      do_read("parity", 8'h3C);

      // Stop bit sampled low
      send_frame(8'h55, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      chk("ferr_pulse", {31'b0, frame_err}, 32'd1);
      chk("ferr_valid", {31'b0, data_valid}, 32'd0);
      chk("ferr_data", {24'b0, data_out}, 32'h3C);
      chk("ferr_busy", {31'b0, busy}, 32'd0);
      tick();
      chk("ferr_one_cycle", {31'b0, frame_err}, 32'd0);

      // Overrun: second byte dropped while first is unread
      send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0, 1'b1);
      check_frame("ovr_first");
      send_frame(8'h22, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      chk("ovr_data_kept", {24'b0, data_out}, 32'h11);
      chk("ovr_flag", {31'b0, overrun}, 32'd1);
      chk("ovr_valid", {31'b0, data_valid}, 32'd1);
      do_read("ovr", 8'h11);
      chk("ovr_sticky", {31'b0, overrun}, 32'd1);

      // Same pair, consumer reads on the second stop edge
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0, 1'b1);
      check_frame("rdstop_first");
      send_frame(8'h22, 1'b0, 1'b1, 0, 1'b1, 1'b1);
      check_frame("rdstop_second");
      chk("rdstop_no_ovr", {31'b0, overrun}, 32'd0);
      do_read("rdstop", 8'h22);

      // Strobe every third cycle
      send_frame(8'hF0, 1'b0, 1'b1, 2, 1'b0, 1'b1);
      chk("gap_dv_before_stop", {31'b0, r_dv_before_stop}, 32'd0);
      check_frame("gap");

      // Reset after the fourth data bit of an aborted frame
      send_bit(1'b0, 0);
      for (int i = 0; i < 4; i++) send_bit(1'b0, 0);
      chk("abort_busy_pre", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      check_all_zero("abort_in_reset");
      tick();
      rst = 1'b0;
      tick();
      tick();
      chk("abort_no_byte", {31'b0, data_valid}, 32'd0);
      send_frame(8'h81, 1'b0, 1'b1, 0, 1'b0, 1'b1);
      check_frame("after_reset");

      chk("sb_drained", q_exp.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
